// File: rtl/fdiv_mul.sv
// fdiv_mul: back end of the floating-point divider.
// Computes x / y as x * (1/y), using the reciprocal mantissa from the table
// stage. Two registered stages with valid/ready flow control:
//   A: mantissa product, raw exponent, sign and special-case flags
//   B: normalised, truncated, special-case-resolved quotient (drives q)
module fdiv_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [22:0] r_m,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q
);

  // Pipeline occupancy and load enables.
  logic va, vb;
  logic a_load, b_load;

  // Register A contents.
  logic               a_s;
  logic               a_inf;
  logic               a_zero;
  logic signed [9:0]  a_e;
  logic        [47:0] a_p;

  // Register B contents.
  logic [31:0] b_q;

  // Stage 1 combinational results.
  logic               s1;
  logic               fy_nz;
  logic        [22:0] mr;
  logic signed [9:0]  er;
  logic signed [9:0]  e1;
  logic        [47:0] p1;
  logic               inf1;
  logic               zero1;

  // Stage 2 combinational results.
  logic signed [9:0]  e2;
  logic        [22:0] m2;
  logic        [31:0] q2;

  // B drains when empty or when the consumer takes q; A drains into B.
  // in_ready depends only on the valid bits and out_ready, never on in_valid.
  assign b_load    = !vb || out_ready;
  assign a_load    = !va || b_load;
  assign in_ready  = a_load;
  assign out_valid = vb;
  assign q         = b_q;

  // Stage 1: reciprocal operand, mantissa product, exponent and special flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s1    = x[31] ^ y[31];
    fy_nz = |y[22:0];
    mr    = 23'd0;
    er    = 10'sd254 - $signed({2'b00, y[30:23]});
    if (fy_nz) begin
      mr = r_m;
      er = 10'sd253 - $signed({2'b00, y[30:23]});
    end
    e1    = $signed({2'b00, x[30:23]}) + er - 10'sd127;
    p1    = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, mr};
    // Priority: divisor exponent 0 or dividend inf -> inf, then divisor inf
    // or dividend zero/denormal -> zero.
    inf1  = (y[30:23] == 8'h00) || (x[30:23] == 8'hFF);
    zero1 = !inf1 && ((y[30:23] == 8'hFF) || (x[30:23] == 8'h00));
  end

  // Stage 2: normalise by one bit, truncate, and resolve underflow/overflow.
  always_comb begin
    e2 = a_e;
    m2 = a_p[45:23];
    if (a_p[47]) begin
      e2 = a_e + 10'sd1;
      m2 = a_p[46:24];
    end
    q2 = {a_s, e2[7:0], m2};
    if (a_inf) begin
      q2 = {a_s, 8'hFF, 23'd0};
    end else if (a_zero) begin
      q2 = {a_s, 31'd0};
    end else if (e2 <= 10'sd0) begin
      q2 = {a_s, 31'd0};
    end else if (e2 >= 10'sd255) begin
      q2 = {a_s, 8'hFF, 23'd0};
    end
  end

  // Register A: captures a new operand set whenever it may load.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data registers are cleared on reset too, so q reads 0 straight out of reset.
    if (rst) begin
      va     <= 1'b0;
      a_s    <= 1'b0;
      a_inf  <= 1'b0;
      a_zero <= 1'b0;
      a_e    <= '0;
      a_p    <= '0;
    end else if (a_load) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      va     <= in_valid;
      a_s    <= s1;
      a_inf  <= inf1;
      a_zero <= zero1;
      a_e    <= e1;
      a_p    <= p1;
    end
  end

  // Register B: takes the finished quotient from A whenever it may load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb  <= 1'b0;
      b_q <= '0;
    end else if (b_load) begin
      vb  <= va;
      b_q <= q2;
    end
  end

endmodule

// File: tb/tb_fdiv_mul.sv
// Testbench for fdiv_mul: directed vectors, backpressure pattern, async reset
// and a randomized stream scored against a behavioural reference model.
module tb_fdiv_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic [22:0] r_m;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;

  fdiv_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .r_m       (r_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    int          age;
  } item_t;

  item_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          or_mode = 0;    // 0: ready, 1: fixed pattern, 2: random, 3: held low
  int          pidx = 0;
  bit          pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] exp_next;
  bit          held = 1'b0;
  logic [31:0] held_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Quotient computed directly from the arithmetic definition.
  function automatic logic [31:0] ref_q(input logic [31:0] xv, input logic [31:0] yv,
                                        input logic [22:0] rmv);
    bit          s;
    int          ex, ey, er, e;
    longint      mx, my, p;
    logic [31:0] inf_v, zero_v, res;
    logic [9:0]  e_bits;
    s      = xv[31] ^ yv[31];
    ex     = int'(xv[30:23]);
    ey     = int'(yv[30:23]);
    inf_v  = {s, 8'hFF, 23'd0};
    zero_v = {s, 31'd0};
    if (ey == 0 || ex == 255) return inf_v;
    if (ey == 255 || ex == 0) return zero_v;
    mx = (longint'(1) << 23) + longint'(xv[22:0]);
    if (yv[22:0] != 23'd0) begin
      my = (longint'(1) << 23) + longint'(rmv);
      er = 253 - ey;
    end else begin
      my = longint'(1) << 23;
      er = 254 - ey;
    end
    p = mx * my;
    e = ex + er - 127;
    if (p >= (longint'(1) << 47)) begin
      e = e + 1;
      p = p >> 1;
    end
    if (e <= 0) return zero_v;
    if (e >= 255) return inf_v;
    e_bits = e[9:0];
    res = {s, e_bits[7:0], 23'd0};
    res[22:0] = p[45:23];
    return res;
  endfunction

  // Reference reciprocal table: 1.r_m ~= 2 / 1.fy.
  function automatic logic [22:0] recip(input logic [22:0] fy);
    longint v;
    if (fy == 23'd0) return 23'd0;
    v = (longint'(1) << 47) / ((longint'(1) << 23) + longint'(fy));
    v = v - (longint'(1) << 23);
    return v[22:0];
  endfunction

  // One clock: choose out_ready, check visible state, account transfers.
  task automatic tick(output bit in_x);
    bit ox;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = pat[pidx % 8];
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    pidx++;
    #2;
    check("in_ready", {31'd0, in_ready}, {31'd0, !(sb.size() == 2 && !out_ready)});
    check("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() > 0 && sb[0].age >= 2)});
    if (held && out_valid) check("q_hold", q, held_q);
    in_x = in_valid && in_ready;
    ox   = out_valid && out_ready;
    if (ox) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        check("q", q, sb[0].q);
        void'(sb.pop_front());
      end
    end
    held   = out_valid && !out_ready;
    held_q = q;
    @(posedge clk);
    #1;
    foreach (sb[i]) sb[i].age++;
    if (in_x) sb.push_back('{q: exp_next, age: 1});
  endtask

  task automatic push_item(input logic [31:0] xv, input logic [31:0] yv,
                           input logic [22:0] rmv, input logic [31:0] expq);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      in_valid = 1'b1;
      x        = xv;
      y        = yv;
      r_m      = rmv;
      exp_next = expq;
      tick(acc);
    end
    check("accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    x        = $urandom;
    y        = $urandom;
  endtask

  task automatic idle(input int n);
    bit dummy;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      x        = $urandom;
      tick(dummy);
    end
  endtask

  task automatic drain();
    bit dummy;
    in_valid = 1'b0;
    for (int i = 0; i < 30 && sb.size() > 0; i++) tick(dummy);
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] xr, yr;
    logic [22:0] rr;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    r_m       = '0;
    #1;
    check("reset_q", q, 32'h0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed values, streaming.
    or_mode = 0;
    push_item(32'h40C00000, 32'h40000000, 23'h155555, 32'h40400000);
    push_item(32'h3F800000, 32'h40800000, 23'h7ABCDE, 32'h3E800000);
    push_item(32'h3F800000, 32'h00000000, 23'h123456, 32'h7F800000);
    push_item(32'h3F800000, 32'h80000000, 23'h123456, 32'hFF800000);
    push_item(32'h00000000, 32'h00000000, 23'h000000, 32'h7F800000);
    push_item(32'h7F000000, 32'h3E800000, 23'h2AAAAA, 32'h7F800000);
    push_item(32'h00800000, 32'h40800000, 23'h2AAAAA, 32'h00000000);
    push_item(32'h7F800000, 32'h40000000, 23'h000000, 32'h7F800000);
    push_item(32'h3F800000, 32'hFF800000, 23'h000000, 32'h80000000);
    push_item(32'h3F800000, 32'h3FC00000, 23'h2AAAAA, 32'h3F2AAAAA);
    drain();

    // Backpressure: 10 back-to-back transfers against a fixed ready pattern.
    or_mode = 1;
    pidx    = 0;
    for (int i = 0; i < 10; i++) begin
      xr = 32'h3F800000 + (i << 20);
      yr = 32'h40000000 + (i << 18);
      rr = recip(yr[22:0]);
      push_item(xr, yr, rr, ref_q(xr, yr, rr));
    end
    drain();

    // Randomised stream against the reference model.
    or_mode = 2;
    for (int i = 0; i < 200; i++) begin
      xr = $urandom;
      yr = $urandom;
      if ($urandom_range(0, 3) != 0) xr[30:23] = 8'(100 + $urandom_range(0, 55));
      if ($urandom_range(0, 3) != 0) yr[30:23] = 8'(100 + $urandom_range(0, 55));
      if ($urandom_range(0, 7) == 0) yr[22:0] = 23'd0;
      rr = recip(yr[22:0]);
      if ($urandom_range(0, 4) == 0) idle(1);
      push_item(xr, yr, rr, ref_q(xr, yr, rr));
    end
    drain();

    // Fill both stages under stall, then reset asynchronously mid-cycle.
    or_mode = 3;
    push_item(32'h40C00000, 32'h40000000, 23'h0, 32'h40400000);
    push_item(32'h3F800000, 32'h40800000, 23'h0, 32'h3E800000);
    out_ready = 1'b0;
    #2;
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_q", q, 32'h0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    held = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // First item after reset: latency checked by the out_valid tracking.
    or_mode = 0;
    push_item(32'h3F800000, 32'h3FC00000, 23'h2AAAAA, 32'h3F2AAAAA);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
